// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Request/grant/response bundle between the pipeline requesters and the
//   memory port arbiter. The fetch side is read-only. The data side carries
//   loads, stores, pushes and pops.
//
//   Signals
//     f_req, f_addr                 fetch request, held until f_gnt
//     f_gnt                         fetch accepted this cycle (combinational)
//     f_rvalid, f_rdata             fetch read data, one cycle after f_gnt
//     d_req, d_we, d_addr, d_wdata  data request, held until d_gnt
//     d_gnt                         data accepted this cycle (combinational)
//     d_rvalid, d_rdata             data completion, one cycle after d_gnt
//
//   Modports
//     master  requester side (pipeline stages)
//     slave   arbiter side
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 256x8 synchronous-read memory among three users: instruction
//   fetch, data access and the internal vector-read engine. The vector engine
//   reads M[0] after reset and M[1] on interrupt, then presents the value on
//   vec_pc for one cycle. This block owns every memory enable.
//
//   Priority: BOOT > data > interrupt vector > fetch.
//
//   Build option
//     MEM_ARB_FAIRNESS_EN  when defined, a fetch that has been denied for
//                          STARVE_MAX consecutive RUN cycles wins over data
//                          once. When undefined, data always beats fetch.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     bus             fetch/data handshake (slave modport)
//     int_req         interrupt request pulse
//     vec_valid       one-cycle pulse, vec_pc/vec_src valid
//     vec_pc          vector value read from memory
//     vec_src         0 = reset vector, 1 = interrupt vector
//     busy            high while booting or waiting for a vector
//     mem_en, mem_we, mem_addr, mem_wdata   memory request
//     mem_rdata       memory read data, one cycle after a read
//
//   States
//     state      | meaning
//     BOOT       | read M[0], nothing else granted
//     VEC_WAIT   | vector data on mem_rdata; data may be granted, fetch held
//     RUN        | normal arbitration, may issue the interrupt vector read
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  input  logic                int_req,
  output logic                vec_valid,
  output logic [DATA_W-1:0]   vec_pc,
  output logic                vec_src,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_VEC_WAIT = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic int_pend_q;
  logic vec_src_q;
  logic f_rvalid_q;
  logic d_rvalid_q;

  logic f_gnt;
  logic d_gnt;
  logic boot_rd;
  logic vec_rd;
  logic fetch_force;

  // State register and response/side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      int_pend_q <= 1'b0;
      vec_src_q  <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= d_gnt;
      if (boot_rd) begin
        vec_src_q <= 1'b0;
      end else if (vec_rd) begin
        vec_src_q <= 1'b1;
      end
      // A pulse arriving in the same cycle the pending flag is consumed
      // starts a fresh pending interrupt rather than being lost.
      if (vec_rd) begin
        int_pend_q <= int_req;
      end else begin
        int_pend_q <= int_pend_q | int_req;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:     state_d = ST_VEC_WAIT;
      ST_VEC_WAIT: state_d = ST_RUN;
      ST_RUN: begin
        if (int_pend_q && !bus.d_req) begin
          state_d = ST_VEC_WAIT;
        end
      end
      default:     state_d = ST_BOOT;
    endcase
  end

  // Output logic: grant selection and memory request mux
  always_comb begin
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    boot_rd   = 1'b0;
    vec_rd    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (!rst) begin
      case (state_q)
        ST_BOOT: begin
          boot_rd = 1'b1;
        end
        ST_VEC_WAIT: begin
          d_gnt = bus.d_req;
        end
        ST_RUN: begin
          if (int_pend_q && !bus.d_req) begin
            vec_rd = 1'b1;
          end else if (bus.d_req && !fetch_force) begin
            d_gnt = 1'b1;
          end else if (bus.f_req) begin
            f_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (boot_rd || vec_rd) begin
      mem_en   = 1'b1;
      mem_addr = vec_rd ? ADDR_W'(1) : ADDR_W'(0);
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
    end else if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.f_addr;
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q;

  // Only consulted in RUN when data also requests, so the vector read and
  // BOOT are never displaced by it.
  assign fetch_force = bus.f_req && (starve_cnt_q == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (!bus.f_req || f_gnt) begin
      starve_cnt_q <= '0;
    end else if (state_q == ST_RUN && starve_cnt_q != CNT_W'(STARVE_MAX)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`else
  assign fetch_force = 1'b0;
`endif

  assign bus.f_gnt    = f_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rdata  = mem_rdata;
  assign bus.d_rdata  = mem_rdata;

  // The vector read was issued in the cycle before VEC_WAIT; a reset landing
  // in VEC_WAIT drops it.
  assign vec_valid = (state_q == ST_VEC_WAIT) && !rst;
  assign vec_pc    = mem_rdata;
  assign vec_src   = vec_src_q;
  assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_req;
  logic       vec_valid;
  logic [7:0] vec_pc;
  logic       vec_src;
  logic       busy;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .int_req   (int_req),
    .vec_valid (vec_valid),
    .vec_pc    (vec_pc),
    .vec_src   (vec_src),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous read, one cycle latency
  logic [7:0] mem [256];
  logic [7:0] rdata_q = 8'h00;
  assign mem_rdata = rdata_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        rdata_q <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       f_gnt;
    logic       d_gnt;
    logic       en;
    logic [7:0] addr;
    logic       we;
    int         busy;   // -1 = not checked
  } cyc_exp_t;

  typedef struct {
    logic [7:0] data;
    logic       is_wr;
  } d_exp_t;

  typedef struct {
    logic [7:0] pc;
    logic       src;
  } v_exp_t;

  cyc_exp_t   cyc_q[$];
  logic [7:0] f_q[$];
  d_exp_t     d_q[$];
  v_exp_t     v_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (cyc_q.size() != 0) begin
      cyc_exp_t e;
      e = cyc_q.pop_front();
      chk("f_gnt", {7'd0, bus.f_gnt}, {7'd0, e.f_gnt});
      chk("d_gnt", {7'd0, bus.d_gnt}, {7'd0, e.d_gnt});
      chk("mem_en", {7'd0, mem_en}, {7'd0, e.en});
      if (e.en) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", {7'd0, mem_we}, {7'd0, e.we});
      end
      if (e.busy >= 0) chk("busy", {7'd0, busy}, 8'(e.busy));
    end
    if (bus.f_rvalid) begin
      if (f_q.size() == 0) chk("f_rvalid_unexpected", 8'd1, 8'd0);
      else chk("f_rdata", bus.f_rdata, f_q.pop_front());
    end
    if (bus.d_rvalid) begin
      if (d_q.size() == 0) chk("d_rvalid_unexpected", 8'd1, 8'd0);
      else begin
        d_exp_t de;
        de = d_q.pop_front();
        if (de.is_wr) chk("d_rvalid_write", {7'd0, bus.d_rvalid}, 8'd1);
        else chk("d_rdata", bus.d_rdata, de.data);
      end
    end
    if (vec_valid) begin
      if (v_q.size() == 0) chk("vec_valid_unexpected", 8'd1, 8'd0);
      else begin
        v_exp_t ve;
        ve = v_q.pop_front();
        chk("vec_pc", vec_pc, ve.pc);
        chk("vec_src", {7'd0, vec_src}, {7'd0, ve.src});
      end
    end
  end

  function automatic void push_f(input logic [7:0] d);
    f_q.push_back(d);
  endfunction
  function automatic void push_d(input logic [7:0] d, input logic w);
    d_exp_t e;
    e.data = d; e.is_wr = w;
    d_q.push_back(e);
  endfunction
  function automatic void push_v(input logic [7:0] pc, input logic src);
    v_exp_t e;
    e.pc = pc; e.src = src;
    v_q.push_back(e);
  endfunction

  // One clock of stimulus plus the expected combinational outputs for it
  task automatic cyc(input logic r, input logic fr, input logic [7:0] fa,
                     input logic dr, input logic dw, input logic [7:0] da,
                     input logic [7:0] dd, input logic ir,
                     input logic efg, input logic edg, input logic een,
                     input logic [7:0] ead, input logic ewe, input int ebusy);
    cyc_exp_t e;
    rst         = r;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    int_req     = ir;
    e.f_gnt = efg; e.d_gnt = edg; e.en = een; e.addr = ead; e.we = ewe; e.busy = ebusy;
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h02;
    mem[8'h01] = 8'h6E;
    mem[8'h02] = 8'h21;
    mem[8'h03] = 8'h19;
    mem[8'h04] = 8'h31;
    mem[8'h05] = 8'h77;
    mem[8'h06] = 8'h66;
    mem[8'h80] = 8'h5A;

    rst = 1'b1; int_req = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = 8'h00;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    @(posedge clk);
    #1;

    // Reset held 3 cycles with requests present: nothing granted
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 8'h02, 1, 0, 8'h80, 8'h00, 0,  0, 0, 0, 8'h00, 0, -1);

    // Boot: read M[0], then vector, then fetch allowed
    push_v(8'h02, 1'b0);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  0, 0, 1, 8'h00, 0, 1);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);

    // Fetch stream
    push_f(8'h21);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h02, 0, 0);
    push_f(8'h19);
    cyc(0, 1, 8'h03, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h03, 0, 0);
    push_f(8'h31);
    cyc(0, 1, 8'h04, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h04, 0, 0);

    // Contention: data first, fetch next cycle
    push_d(8'h5A, 1'b0);
    cyc(0, 1, 8'h05, 1, 0, 8'h80, 8'h00, 0,  0, 1, 1, 8'h80, 0, 0);
    push_f(8'h77);
    cyc(0, 1, 8'h05, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h05, 0, 0);

    // Starvation: 6 contested cycles
    for (int i = 0; i < 6; i++) begin
      logic fw;
`ifdef MEM_ARB_FAIRNESS_EN
      fw = (i == 4);
`else
      fw = 1'b0;
`endif
      if (fw) begin
        push_f(8'h66);
        cyc(0, 1, 8'h06, 1, 0, 8'h80, 8'h00, 0,  1, 0, 1, 8'h06, 0, 0);
      end else begin
        push_d(8'h5A, 1'b0);
        cyc(0, 1, 8'h06, 1, 0, 8'h80, 8'h00, 0,  0, 1, 1, 8'h80, 0, 0);
      end
    end
    push_f(8'h66);
    cyc(0, 1, 8'h06, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h06, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0);

    // Interrupt with fetch active, data idle
    push_f(8'h21);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h02, 0, 0);
    push_v(8'h6E, 1'b1);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  0, 0, 1, 8'h01, 0, 0);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);
    push_f(8'h21);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h02, 0, 0);

    // Store/load while two interrupt pulses merge behind data
    push_d(8'h00, 1'b1);
    cyc(0, 0, 8'h00, 1, 1, 8'h40, 8'hA5, 1,  0, 1, 1, 8'h40, 1, 0);
    push_d(8'hA5, 1'b0);
    cyc(0, 0, 8'h00, 1, 0, 8'h40, 8'h00, 1,  0, 1, 1, 8'h40, 0, 0);
    push_v(8'h6E, 1'b1);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  0, 0, 1, 8'h01, 0, 0);
    push_d(8'h5A, 1'b0);
    cyc(0, 1, 8'h02, 1, 0, 8'h80, 8'h00, 0,  0, 1, 1, 8'h80, 0, 1);
    push_f(8'h21);
    cyc(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h02, 0, 0);

    // Reset during VEC_WAIT: vector dropped, boot re-reads M[0]
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 1, 8'h01, 0, 0);
    cyc(1, 1, 8'h02, 1, 0, 8'h80, 8'h00, 0,  0, 0, 0, 8'h00, 0, -1);
    push_v(8'h02, 1'b0);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 1, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);
    push_f(8'h31);
    cyc(0, 1, 8'h04, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h04, 0, 0);

    for (int i = 0; i < 3; i++)
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0);

    chk("f_q_drained", 8'(f_q.size()), 8'd0);
    chk("d_q_drained", 8'(d_q.size()), 8'd0);
    chk("v_q_drained", 8'(v_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
